branch_prediction_unit: RTL and testbench
=========================================

Name: branch_prediction_unit

Overview:
- Dynamic branch predictor that directly feeds the PC select stage in the hazard unit.
- Predicts conditional branches decoded in ID using a table of 2-bit saturating counters, and drives TAKE_BRANCH to redirect fetch early.
- Carries each prediction to EX and compares it with the resolved outcome. On mismatch it raises FLUSH, with EARLY_PREDICTION telling the PC mux which recovery address to use.
- Also keeps branch and mispredict statistics.

Parameters:
- INDEX_BITS, 6, log2 of branch history table (BHT) entries; index = PC[INDEX_BITS+1:2].
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- ID_PC  input  32  PC of the instruction in ID.
- ID_IS_BRANCH  input  1  the ID instruction is a conditional branch.
- STALL  input  1  ID held this cycle; EX receives a bubble.
- EX_BRANCH_RESULT  input  1  actual outcome of the EX branch (1 = taken); sampled only when the internal EX valid bit is 1.
- TAKE_BRANCH  output  1  predict-taken for the ID branch; the PC mux selects the ID branch target.
- EARLY_PREDICTION  output  1  prediction that was made for the branch now in EX.
- FLUSH  output  1  the EX branch was mispredicted.
- BRANCH_COUNT  output  CNT_WIDTH  branches resolved since reset.
- MISPREDICT_COUNT  output  CNT_WIDTH  mispredictions since reset.

Behaviour:
- BHT:
  - 2^INDEX_BITS entries of 2 bits each; encoding 00 SNT, 01 WNT, 10 WT, 11 ST.
  - Reset sets all entries to 01.
- ID lookup (combinational):
  - id_idx = ID_PC[INDEX_BITS+1:2].
  - TAKE_BRANCH = ID_IS_BRANCH & BHT[id_idx][1] & ~FLUSH & ~STALL.
- ID/EX shadow register (ex_valid, ex_pred, ex_idx), updated each rising edge:
  - If FLUSH or STALL: ex_valid<=0 and ex_pred<=0. Flush has priority; a squashed ID branch is never tracked.
  - Else: ex_valid<=ID_IS_BRANCH, ex_pred<=BHT[id_idx][1] & ID_IS_BRANCH, ex_idx<=id_idx.
- EX resolve (combinational):
  - EARLY_PREDICTION = ex_pred.
  - FLUSH = ex_valid & (EX_BRANCH_RESULT != ex_pred).
  - The PC mux maps FLUSH&EARLY_PREDICTION to the PC+4 recovery path and FLUSH&~EARLY_PREDICTION to the branch target.
- BHT update, at the rising edge while ex_valid=1:
  - Taken: saturating increment (11 stays 11).
  - Not taken: saturating decrement (00 stays 00).
  - Exactly one entry is written per cycle.
- Same-entry read/write in one cycle (id_idx==ex_idx, ex_valid=1): the ID lookup uses the pre-update value. No bypass.
- Statistics:
  - BRANCH_COUNT += 1 each edge with ex_valid=1.
  - MISPREDICT_COUNT += 1 each edge with FLUSH=1.
  - Both wrap modulo 2^CNT_WIDTH.
- Latency: prediction is zero-cycle (combinational in ID). Resolve/flush occurs one cycle after ID when not stalled.
- Reset:
  - RESET low clears the shadow register and counters immediately and sets the BHT to 01.
  - Outputs then read TAKE_BRANCH=0, EARLY_PREDICTION=0, FLUSH=0, counts=0.
  - Reset asserted mid-operation discards any in-flight branch without a flush.

Decomposition:
- Shared package holds:
  - the 2-bit counter encodings (SNT/WNT/WT/ST);
  - the reset value WNT;
  - the index-slicing function for PC -> BHT index.
- One sub-module, bp_sat_counter: a combinational 2-bit saturating next-state function (current, taken -> next). It is instanced once in the update path.
- The BHT array and statistics registers stay in the top module.

Test Plan:
- Reset then single branch: ID_PC=0x100, ID_IS_BRANCH=1 -> TAKE_BRANCH=0. Next cycle EX_BRANCH_RESULT=1 -> FLUSH=1, EARLY_PREDICTION=0; BHT[0x00] becomes 10; counts 1/1.
- Training: same PC resolved taken twice more -> BHT saturates at 11. A fourth lookup gives TAKE_BRANCH=1, and EX result 1 gives FLUSH=0. A later result of 0 gives FLUSH=1, EARLY_PREDICTION=1, and BHT goes to 10.
- Aliasing/indexing: PCs 0x100 and 0x200 (INDEX_BITS=6) share index 0 and update the same entry. PC 0x104 uses index 1 and is unaffected.
- Flush squash: FLUSH=1 while ID_IS_BRANCH=1 -> TAKE_BRANCH=0. Next cycle ex_valid=0, FLUSH=0, and BRANCH_COUNT is unchanged.
- Stall: STALL=1 with a branch in ID -> TAKE_BRANCH=0 and EX gets a bubble. The same-cycle EX update still occurs.
- Same-index hazard and reset: back-to-back branches at PC 0x100 with the first resolving taken from 01 -> the second's prediction uses 01 (not taken). Asserting RESET low mid-sequence zeroes the counts and the BHT reads 01.

Source files
------------

// File: rtl/branch_prediction_unit_pkg.sv
// rtl/branch_prediction_unit_pkg.sv - shared counter encodings and PC-to-index helper for the branch predictor
package branch_prediction_unit_pkg;

    // 2-bit saturating counter states held in each BHT entry
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

    // Every entry starts weakly not-taken so one taken outcome flips it
    localparam logic [1:0] BHT_RESET = WNT;

    // Word-aligned PCs: drop the byte offset, keep index_bits of the word address
    function automatic logic [31:0] bht_index(input logic [31:0] pc, input int index_bits);
        logic [31:0] mask;
        mask = (32'd1 << index_bits) - 32'd1;
        return (pc >> 2) & mask;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - combinational next-state of a 2-bit saturating branch counter
module bp_sat_counter
    import branch_prediction_unit_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    // Step toward ST on taken, toward SNT on not taken, holding at either end
    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != ST) begin
                nxt = cur + 2'd1;
            end
        end else begin
            if (cur != SNT) begin
                nxt = cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_prediction_unit.sv
// rtl/branch_prediction_unit.sv - 2-bit BHT predictor with ID lookup, EX resolve/flush and statistics
module branch_prediction_unit
    import branch_prediction_unit_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          ID_PC,
    input  logic                 ID_IS_BRANCH,
    input  logic                 STALL,
    input  logic                 EX_BRANCH_RESULT,
    output logic                 TAKE_BRANCH,
    output logic                 EARLY_PREDICTION,
    output logic                 FLUSH,
    output logic [CNT_WIDTH-1:0] BRANCH_COUNT,
    output logic [CNT_WIDTH-1:0] MISPREDICT_COUNT
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            bht [ENTRIES];
    logic [INDEX_BITS-1:0] id_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic                  ex_valid;
    logic                  ex_pred;
    logic                  id_pred;
    logic [1:0]            ex_cnt;
    logic [1:0]            ex_cnt_next;
    logic [CNT_WIDTH-1:0]  branch_count;
    logic [CNT_WIDTH-1:0]  mispredict_count;

    // ID lookup reads the registered table, so a same-entry update this cycle is not seen
    assign id_idx  = INDEX_BITS'(bht_index(ID_PC, INDEX_BITS));
    assign id_pred = bht[id_idx][1];

    // EX resolve: a mismatch between the carried prediction and the real outcome flushes
    assign EARLY_PREDICTION = ex_pred;
    assign FLUSH            = ex_valid & (EX_BRANCH_RESULT != ex_pred);
    assign TAKE_BRANCH      = ID_IS_BRANCH & id_pred & ~FLUSH & ~STALL;

    assign BRANCH_COUNT     = branch_count;
    assign MISPREDICT_COUNT = mispredict_count;

    assign ex_cnt = bht[ex_idx];

    bp_sat_counter u_sat_counter (
        .cur   (ex_cnt),
        .taken (EX_BRANCH_RESULT),
        .nxt   (ex_cnt_next)
    );

    // ID/EX shadow: carry the prediction forward, inserting a bubble on flush or stall
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ex_valid <= 1'b0;
            ex_pred  <= 1'b0;
            ex_idx   <= '0;
        end else if (FLUSH || STALL) begin
            ex_valid <= 1'b0;
            ex_pred  <= 1'b0;
        end else begin
            ex_valid <= ID_IS_BRANCH;
            ex_pred  <= id_pred & ID_IS_BRANCH;
            ex_idx   <= id_idx;
        end
    end

    // BHT: train the single entry of the branch resolving in EX
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= BHT_RESET;
            end
        end else if (ex_valid) begin
            bht[ex_idx] <= ex_cnt_next;
        end
    end

    // Statistics: resolved branches and mispredictions, wrapping naturally
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (ex_valid) begin
                branch_count <= branch_count + 1'b1;
            end
            if (FLUSH) begin
                mispredict_count <= mispredict_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_prediction_unit.sv
// tb/tb_branch_prediction_unit.sv - directed scoreboard bench for branch_prediction_unit
module tb_branch_prediction_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] ID_PC;
    logic        ID_IS_BRANCH;
    logic        STALL;
    logic        EX_BRANCH_RESULT;
    logic        TAKE_BRANCH;
    logic        EARLY_PREDICTION;
    logic        FLUSH;
    logic [31:0] BRANCH_COUNT;
    logic [31:0] MISPREDICT_COUNT;

    branch_prediction_unit #(
        .INDEX_BITS (6),
        .CNT_WIDTH  (32)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .ID_PC            (ID_PC),
        .ID_IS_BRANCH     (ID_IS_BRANCH),
        .STALL            (STALL),
        .EX_BRANCH_RESULT (EX_BRANCH_RESULT),
        .TAKE_BRANCH      (TAKE_BRANCH),
        .EARLY_PREDICTION (EARLY_PREDICTION),
        .FLUSH            (FLUSH),
        .BRANCH_COUNT     (BRANCH_COUNT),
        .MISPREDICT_COUNT (MISPREDICT_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       pred;
        logic [5:0] idx;
    } sb_t;

    sb_t         sb[$];
    logic [1:0]  m_bht [64];
    logic [31:0] m_bc;
    logic [31:0] m_mc;
    int          total;
    int          passed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        sb.delete();
        m_bc = 0;
        m_mc = 0;
    endtask

    // One cycle: drive ID/EX inputs, check against model and optional plan literals, clock, update model
    task automatic step(input logic [31:0] pc, input logic br, input logic stl, input logic res,
                        input int lit_take, input int lit_flush);
        logic [5:0] idx;
        logic       exv;
        logic       ep;
        logic       ef;
        logic       et;
        logic       pred;
        ID_PC = pc;
        ID_IS_BRANCH = br;
        STALL = stl;
        EX_BRANCH_RESULT = res;
        #2;
        idx  = pc[7:2];
        exv  = (sb.size() != 0);
        ep   = exv ? sb[0].pred : 1'b0;
        ef   = exv && (res != ep);
        pred = m_bht[idx][1];
        et   = br & pred & ~ef & ~stl;
        chk("take", {31'd0, TAKE_BRANCH}, {31'd0, et});
        chk("flush", {31'd0, FLUSH}, {31'd0, ef});
        chk("early", {31'd0, EARLY_PREDICTION}, {31'd0, ep});
        chk("bcnt", BRANCH_COUNT, m_bc);
        chk("mcnt", MISPREDICT_COUNT, m_mc);
        if (lit_take >= 0) chk("take_plan", {31'd0, TAKE_BRANCH}, 32'(lit_take));
        if (lit_flush >= 0) chk("flush_plan", {31'd0, FLUSH}, 32'(lit_flush));
        @(posedge CLK);
        if (exv) begin
            if (res) begin
                if (m_bht[sb[0].idx] != 2'b11) m_bht[sb[0].idx] = m_bht[sb[0].idx] + 2'd1;
            end else begin
                if (m_bht[sb[0].idx] != 2'b00) m_bht[sb[0].idx] = m_bht[sb[0].idx] - 2'd1;
            end
            m_bc = m_bc + 1;
            if (ef) m_mc = m_mc + 1;
            void'(sb.pop_front());
        end
        if (br && !ef && !stl) sb.push_back('{pred: pred, idx: idx});
        #1;
    endtask

    initial begin
        total = 0;
        passed = 0;
        model_reset();
        RESET = 1'b0;
        ID_PC = 32'h100;
        ID_IS_BRANCH = 1'b1;
        STALL = 1'b0;
        EX_BRANCH_RESULT = 1'b1;
        #1;
        chk("rst_take", {31'd0, TAKE_BRANCH}, 32'd0);
        chk("rst_early", {31'd0, EARLY_PREDICTION}, 32'd0);
        chk("rst_flush", {31'd0, FLUSH}, 32'd0);
        chk("rst_bcnt", BRANCH_COUNT, 32'd0);
        chk("rst_mcnt", MISPREDICT_COUNT, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;

        // First branch from WNT, resolved taken: mispredict, entry to WT
        step(32'h100, 1, 0, 0, 0, -1);
        step(32'h000, 0, 0, 1, -1, 1);
        chk("bcnt_first", BRANCH_COUNT, 32'd1);
        chk("mcnt_first", MISPREDICT_COUNT, 32'd1);

        // Training to ST, then a not-taken outcome mispredicts with EARLY_PREDICTION=1
        step(32'h100, 1, 0, 0, 1, -1);
        step(32'h000, 0, 0, 1, -1, 0);
        step(32'h100, 1, 0, 0, 1, -1);
        step(32'h000, 0, 0, 1, -1, 0);
        step(32'h100, 1, 0, 0, 1, -1);
        step(32'h000, 0, 0, 0, -1, 1);

        // Aliasing: 0x200 shares index 0; its flush squashes the ID branch at 0x104
        step(32'h200, 1, 0, 0, 1, -1);
        step(32'h104, 1, 0, 0, 0, 1);
        step(32'h000, 0, 0, 0, -1, 0);
        chk("squash_bcnt", BRANCH_COUNT, 32'd5);
        step(32'h104, 1, 0, 0, 0, -1);
        step(32'h100, 1, 0, 0, 0, 0);
        step(32'h000, 0, 0, 0, -1, 0);

        // Stall: ID branch suppressed while the EX branch still resolves
        step(32'h104, 1, 0, 0, 0, -1);
        step(32'h100, 1, 1, 0, 0, 0);
        step(32'h000, 0, 0, 0, -1, 0);

        // Train index 0 to ST, leave a predicted-taken branch in EX, then reset mid-flight
        step(32'h100, 1, 0, 0, -1, -1);
        step(32'h000, 0, 0, 1, -1, -1);
        step(32'h100, 1, 0, 0, -1, -1);
        step(32'h000, 0, 0, 1, -1, -1);
        step(32'h100, 1, 0, 0, -1, -1);
        step(32'h000, 0, 0, 1, -1, -1);
        step(32'h100, 1, 0, 0, 1, -1);
        ID_PC = 32'h100;
        ID_IS_BRANCH = 1'b1;
        EX_BRANCH_RESULT = 1'b0;
        RESET = 1'b0;
        #1;
        chk("mid_rst_flush", {31'd0, FLUSH}, 32'd0);
        chk("mid_rst_early", {31'd0, EARLY_PREDICTION}, 32'd0);
        chk("mid_rst_take", {31'd0, TAKE_BRANCH}, 32'd0);
        chk("mid_rst_bcnt", BRANCH_COUNT, 32'd0);
        chk("mid_rst_mcnt", MISPREDICT_COUNT, 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        // Same-index back-to-back after reset: second lookup sees pre-update WNT
        step(32'h100, 1, 0, 0, 0, -1);
        step(32'h100, 1, 0, 1, 0, 1);
        step(32'h000, 0, 0, 0, -1, 0);
        step(32'h000, 0, 0, 0, -1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
